// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared countdown timer.
// The abort line exists only when TIMER_ARB_ABORT_EN is defined.
interface timer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 5
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] delay;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                busy;
`ifdef TIMER_ARB_ABORT_EN
  logic                abort;

  modport master (output req, delay, abort, input gnt, done, busy);
  modport slave  (input req, delay, abort, output gnt, done, busy);
`else
  modport master (output req, delay, input gnt, done, busy);
  modport slave  (input req, delay, output gnt, done, busy);
`endif
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin scheduler for one shared DW-bit countdown timer.
// A requester is granted, its delay is loaded and counted down, and a single
// done pulse is returned to that requester when the count expires.
// Optional macro TIMER_ARB_ABORT_EN adds an abort input that cancels a count.
module timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  timer_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DW-1:0]    rem_q,   rem_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [N_REQ-1:0] done_q,  done_d;
  logic             busy_q,  busy_d;

  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW:0]      cand;
  logic [DW-1:0]    win_dly;
  logic [DW-1:0]    eff_dly;
  logic [PW-1:0]    ptr_next;

  // Round-robin search: first set req bit at or after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (!win_vld && bus.req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // Select the winner's delay; zero is promoted to one so the timer never wraps.
  always_comb begin
    win_dly = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_dly = bus.delay[i*DW +: DW];
      end
    end
    eff_dly  = (win_dly == '0) ? DW'(1) : win_dly;
    ptr_next = (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
  end

  // Next-state logic for the IDLE/COUNT controller and its registered outputs.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d          = COUNT;
          gnt_d[win_idx]   = 1'b1;
          rem_d            = eff_dly;
          owner_d          = win_idx;
          ptr_d            = ptr_next;
        end
      end
      default: begin
`ifdef TIMER_ARB_ABORT_EN
        if (bus.abort) begin
          // Abort beats expiry: the count is dropped without a done pulse.
          state_d = IDLE;
          rem_d   = '0;
        end else
`endif
        if (rem_q > DW'(1)) begin
          rem_d = rem_q - DW'(1);
        end else begin
          done_d[owner_q] = 1'b1;
          rem_d           = '0;
          state_d         = IDLE;
        end
      end
    endcase
    busy_d = (state_d == COUNT);
  end

  // State and output registers; reset abandons any count in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (N_REQ=4, DW=5).
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  timer_arbiter_if #(.N_REQ(4), .DW(5)) bus ();

  timer_arbiter #(.N_REQ(4), .DW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  // Called in the grant cycle G. Checks the grant, busy through G+D-1 and the
  // done pulse in G+D; req is replaced by next_req after the grant is seen.
  task automatic expect_service(input logic [3:0] exp_gnt, input int exp_d,
                                input logic [3:0] next_req, input string tag);
    chk({tag, "_gnt"},  {28'd0, bus.gnt},  {28'd0, exp_gnt});
    chk({tag, "_busy0"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_done0"}, {28'd0, bus.done}, 32'd0);
    bus.req = next_req;
    for (int k = 1; k < exp_d; k++) begin
      step();
      chk({tag, "_cnt"}, {26'd0, bus.gnt, bus.done, bus.busy}, 32'd1);
    end
    step();
    chk({tag, "_done"}, {28'd0, bus.done}, {28'd0, exp_gnt});
    chk({tag, "_idle"}, {27'd0, bus.gnt, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.req   = '0;
    bus.delay = '0;
`ifdef TIMER_ARB_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2 rst = 1'b1;
    step();
    chk("rst_gnt",  {28'd0, bus.gnt},  32'd0);
    chk("rst_done", {28'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;

    // Single request, delay 3.
    bus.req   = 4'b0001;
    bus.delay = {5'd0, 5'd0, 5'd0, 5'd3};
    step();
    expect_service(4'b0001, 3, 4'b0000, "single");

    // All requesting continuously, delay 2: order 0,1,2,3,0 with period 3.
    do_reset();
    bus.req   = 4'b1111;
    bus.delay = {5'd2, 5'd2, 5'd2, 5'd2};
    step();
    expect_service(4'b0001, 2, 4'b1111, "rr0");
    step();
    expect_service(4'b0010, 2, 4'b1111, "rr1");
    step();
    expect_service(4'b0100, 2, 4'b1111, "rr2");
    step();
    expect_service(4'b1000, 2, 4'b1111, "rr3");
    step();
    expect_service(4'b0001, 2, 4'b1111, "rr4");
    bus.req = 4'b0000;

    // Delay 0 behaves as 1; delay 31 counts fully without wrapping.
    bus.req   = 4'b0001;
    bus.delay = {5'd0, 5'd0, 5'd0, 5'd0};
    step();
    expect_service(4'b0001, 1, 4'b0000, "d0");
    bus.req   = 4'b0010;
    bus.delay = {5'd0, 5'd0, 5'd31, 5'd0};
    step();
    expect_service(4'b0010, 31, 4'b0000, "d31");

    // Request raised during a count waits for IDLE, then is granted next cycle.
    bus.req   = 4'b0010;
    bus.delay = {5'd0, 5'd2, 5'd4, 5'd0};
    step();
    expect_service(4'b0010, 4, 4'b0100, "blk1");
    step();
    expect_service(4'b0100, 2, 4'b0000, "blk2");

    // Reset at rem=5 clears outputs at once, no done, ptr restarts at 0.
    bus.req   = 4'b0100;
    bus.delay = {5'd0, 5'd9, 5'd0, 5'd0};
    step();
    chk("mid_gnt", {28'd0, bus.gnt}, 32'h4);
    bus.req = 4'b0000;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {26'd0, bus.gnt, bus.done, bus.busy}, 32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("mid_nodone", {28'd0, bus.done, bus.busy}, 32'd0);
    end
    bus.req   = 4'b1100;
    bus.delay = {5'd2, 5'd2, 5'd0, 5'd0};
    step();
    expect_service(4'b0100, 2, 4'b0000, "post_rst");

`ifdef TIMER_ARB_ABORT_EN
    // Abort while rem==1 suppresses done; next grant continues from ptr=1.
    bus.req   = 4'b0001;
    bus.delay = {5'd0, 5'd0, 5'd0, 5'd3};
    step();
    chk("ab_gnt", {28'd0, bus.gnt}, 32'h1);
    bus.req = 4'b0000;
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_out", {28'd0, bus.done, bus.busy}, 32'd0);
    step();
    chk("ab_nodone", {28'd0, bus.done}, 32'd0);
    bus.req   = 4'b0011;
    bus.delay = {5'd0, 5'd0, 5'd2, 5'd2};
    step();
    expect_service(4'b0010, 2, 4'b0000, "ab_next");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
